// File: rtl/duck_pkg.sv
// Shared types and RNG word field positions for the duck spawn controller.
package duck_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_DLY = 3'd1,
    S_WAIT    = 3'd2,
    S_GET_POS = 3'd3,
    S_PRESENT = 3'd4,
    S_ACTIVE  = 3'd5
  } spawn_state_t;

  localparam int RNG_DLY_LSB = 0;
  localparam int RNG_DLY_MSB = 5;
  localparam int RNG_X_MSB   = 9;
  localparam int RNG_DIR_BIT = 10;
  localparam int RNG_SPD_LSB = 11;

endpackage

// File: rtl/duck_spawn_ctrl_if.sv
// RNG stream and spawn record handshakes between the RNG, the controller and the sprite logic.
interface duck_spawn_ctrl_if;
  logic [31:0] rng_data;
  logic        rng_valid;
  logic        rng_ready;
  logic        spawn_valid;
  logic        spawn_ack;
  logic [9:0]  spawn_x;
  logic        spawn_dir;
  logic [1:0]  spawn_speed;

  modport master (
    input  rng_data, rng_valid, spawn_ack,
    output rng_ready, spawn_valid, spawn_x, spawn_dir, spawn_speed
  );

  modport slave (
    output rng_data, rng_valid, spawn_ack,
    input  rng_ready, spawn_valid, spawn_x, spawn_dir, spawn_speed
  );
endinterface

// File: rtl/spawn_field_decode.sv
// Combinational map of one RNG word to spawn x (single fold into range), direction and speed.
module spawn_field_decode
  import duck_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int DUCK_W   = 32
) (
  input  logic [31:0] word,
  output logic [9:0]  x,
  output logic        dir,
  output logic [1:0]  speed
);

  localparam logic [9:0] X_LIM = 10'(SCREEN_W - DUCK_W);

  logic [9:0] r;
  logic [1:0] spd_raw;
  logic       unused_word_hi;

  assign r              = word[RNG_X_MSB:0];
  assign spd_raw        = word[RNG_SPD_LSB +: 2];
  assign unused_word_hi = ^word[31:RNG_SPD_LSB+2];

  // 10-bit r never exceeds 2*X_LIM, so one subtract always lands in range
  assign x     = (r < X_LIM) ? r : r - X_LIM;
  assign dir   = word[RNG_DIR_BIT];
  assign speed = (spd_raw == 2'd0) ? 2'd1 : spd_raw;

endmodule

// File: rtl/duck_spawn_ctrl.sv
// Duck spawn controller: random frame delay, then a random spawn record per duck.
// Optional DUCK_SPAWN_STATS_EN adds a saturating count of acknowledged spawns.
//
// state     | meaning
// IDLE      | game stopped, nothing requested
// GET_DLY   | pulling the RNG word for the inter-spawn delay
// WAIT      | counting frame ticks down to zero
// GET_POS   | pulling the RNG word for x/dir/speed
// PRESENT   | spawn record offered, waiting for ack
// ACTIVE    | duck on screen, waiting for duck_done
module duck_spawn_ctrl
  import duck_pkg::*;
#(
  parameter int SCREEN_W  = 640,
  parameter int DUCK_W    = 32,
  parameter int MIN_DELAY = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic game_en,
  input  logic frame_tick,
  input  logic duck_done,
`ifdef DUCK_SPAWN_STATS_EN
  output logic [15:0] spawn_count,
`endif
  duck_spawn_ctrl_if.master bus
);

  spawn_state_t state, state_nxt;
  logic [6:0]   delay_cnt;
  logic         take;
  logic [9:0]   dec_x;
  logic         dec_dir;
  logic [1:0]   dec_speed;
  logic         unused_rng_hi;

  assign unused_rng_hi = ^bus.rng_data[31:RNG_DLY_MSB+1];

  spawn_field_decode #(.SCREEN_W(SCREEN_W), .DUCK_W(DUCK_W)) u_decode (
    .word  (bus.rng_data),
    .x     (dec_x),
    .dir   (dec_dir),
    .speed (dec_speed)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!game_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_GET_DLY;
        S_GET_DLY: if (bus.rng_valid)     state_nxt = S_WAIT;
        S_WAIT:    if (delay_cnt == 7'd0) state_nxt = S_GET_POS;
        S_GET_POS: if (bus.rng_valid)     state_nxt = S_PRESENT;
        S_PRESENT: if (bus.spawn_ack)     state_nxt = S_ACTIVE;
        S_ACTIVE:  if (duck_done)         state_nxt = S_GET_DLY;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rng_ready   = (state == S_GET_DLY) || (state == S_GET_POS);
    bus.spawn_valid = (state == S_PRESENT);
    take            = bus.rng_ready && bus.rng_valid && game_en;
  end

  // Ticks on the loading cycle are dropped because the load takes priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_cnt       <= '0;
      bus.spawn_x     <= '0;
      bus.spawn_dir   <= 1'b0;
      bus.spawn_speed <= '0;
    end else begin
      if (!game_en)
        delay_cnt <= '0;
      else if (take && state == S_GET_DLY)
        delay_cnt <= 7'(MIN_DELAY) + {1'b0, bus.rng_data[RNG_DLY_MSB:RNG_DLY_LSB]};
      else if (state == S_WAIT && frame_tick && delay_cnt != 7'd0)
        delay_cnt <= delay_cnt - 7'd1;

      if (take && state == S_GET_POS) begin
        bus.spawn_x     <= dec_x;
        bus.spawn_dir   <= dec_dir;
        bus.spawn_speed <= dec_speed;
      end
    end
  end

`ifdef DUCK_SPAWN_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      spawn_count <= '0;
    else if (bus.spawn_valid && bus.spawn_ack && spawn_count != 16'hFFFF)
      spawn_count <= spawn_count + 16'd1;
  end
`endif

endmodule

// File: doc/duck_spawn_ctrl.md
# duck_spawn_ctrl

Consumer end of the xorshift RNG stream for the Duck Hunt game. It pulls 32-bit random words from `xorshift_rng` over a valid/ready handshake and turns them into duck spawn events: a random inter-spawn delay in video frames, then a spawn record with x position, direction and speed. The spawn record is handed to the game/sprite logic over a valid/ack handshake. It sits between the RNG and the duck sprite controller.

## Interface
- `SCREEN_W`, default 640: visible width in pixels.
- `DUCK_W`, default 32: duck sprite width in pixels. The x range is 0..SCREEN_W-DUCK_W-1.
- `MIN_DELAY`, default 30: minimum number of frames between spawns.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `game_en`  in  1  game running. Low forces the block to IDLE.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `rng_data`  in  32  random word from the RNG.
- `rng_valid`  in  1  `rng_data` is valid.
- `rng_ready`  out  1  block will consume `rng_data` this cycle.
- `duck_done`  in  1  one-cycle pulse when the current duck is hit or has escaped.
- `spawn_valid`  out  1  spawn record is valid.
- `spawn_ack`  in  1  consumer accepts the spawn record.
- `spawn_x`  out  10  spawn x position.
- `spawn_dir`  out  1  direction: 0 = left, 1 = right.
- `spawn_speed`  out  2  speed, 1..3.

## Operation
- FSM states: IDLE, GET_DLY, WAIT, GET_POS, PRESENT, ACTIVE.
- IDLE → GET_DLY when `game_en` = 1.
- GET_DLY:
  - `rng_ready` = 1.
  - On `rng_valid` & `rng_ready`, load `delay_cnt` = MIN_DELAY + `rng_data[5:0]` (range 30..93). Go to WAIT.
- WAIT:
  - Decrement `delay_cnt` on each `frame_tick`.
  - When `delay_cnt` = 0 is reached, go to GET_POS.
  - If a tick arrives while `delay_cnt` is already 0, the counter holds at 0 and does not wrap.
- GET_POS:
  - `rng_ready` = 1.
  - On handshake, latch the spawn fields:
    - `r` = `rng_data[9:0]`. `spawn_x` = `r` if `r` < SCREEN_W-DUCK_W (608), else `r`-608 (a single conditional subtract; the result is always < 608).
    - `spawn_dir` = `rng_data[10]`.
    - `spawn_speed` = `rng_data[12:11]`, with the value 0 mapped to 1.
  - Go to PRESENT.
- PRESENT:
  - `spawn_valid` = 1.
  - Fields stay stable until `spawn_ack`; then go to ACTIVE.
- ACTIVE:
  - Wait for `duck_done`, then go to GET_DLY.
  - A `duck_done` pulse in any other state is ignored.
- `game_en` = 0 in any state: next cycle go to IDLE. `spawn_valid` and `rng_ready` drop to 0 and `delay_cnt` clears.
- Words are consumed only in GET_DLY and GET_POS. Every other RNG word is untouched; the RNG free-runs.

## Timing
- Reset (`rst_n` = 0 at a clk edge), including mid-operation:
  - State = IDLE.
  - `rng_ready` = 0, `spawn_valid` = 0, `spawn_x` = 0, `spawn_dir` = 0, `spawn_speed` = 0, `delay_cnt` = 0.
- `rng_ready` is a registered-state decode, so it is high for the whole of GET_DLY and GET_POS. The word is consumed in the cycle `rng_valid` & `rng_ready`, and the state changes at the next edge.
- If `rng_valid` stays low, the block waits indefinitely with `rng_ready` held.
- Latency:
  - From the GET_POS handshake edge, `spawn_valid` is high on the next cycle.
  - From `spawn_ack` while `spawn_valid` is high, `spawn_valid` is low on the next cycle.
- `spawn_ack` while `spawn_valid` = 0 is ignored.
- `duck_done` and `game_en` = 0 in the same cycle: `game_en` wins.
- `frame_tick` and the transition into WAIT in the same cycle: the tick is not counted.
- All fields are registered; there are no combinational paths from inputs to outputs except none.

## Configuration
- `DUCK_SPAWN_STATS_EN` defined:
  - Adds output `spawn_count` [15:0].
  - It increments on each `spawn_ack` handshake and saturates at 16'hFFFF.
  - It is cleared by reset only; `game_en` does not clear it.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `duck_pkg`:
  - FSM state encoding (`spawn_state_t`).
  - Field bit positions (`RNG_DLY_LSB`/`MSB`, `RNG_X_MSB`, `RNG_DIR_BIT`, `RNG_SPD_LSB`).
- One sub-module: `spawn_field_decode`, the combinational mapping of the 32-bit word to x/dir/speed (fold and speed remap). It is reused by the bench's reference model.

## Test plan
- Reset then `game_en` = 1, RNG word 0x0000_0005 in GET_DLY → exactly 35 `frame_tick`s elapse before `rng_ready` reasserts (GET_POS).
- GET_POS word 0x0000_1E70 (`r` = 624, bit 10 = 1, speed = 3) → `spawn_x` = 16, `spawn_dir` = 1, `spawn_speed` = 3, `spawn_valid` = 1 one cycle after the handshake.
- GET_POS word 0x0000_0100 → `spawn_x` = 256, `spawn_dir` = 0, `spawn_speed` = 1 (0 remapped). Hold `spawn_ack` low 10 cycles → fields are stable throughout.
- `rng_valid` low for 20 cycles in GET_DLY → `rng_ready` stays high and no state change. Pulse `duck_done` in WAIT → ignored.
- Drop `game_en` during PRESENT, and separately pulse `rst_n` low during WAIT → `spawn_valid` = 0 and state IDLE next cycle; outputs at reset values after reset.
- With `DUCK_SPAWN_STATS_EN`: three full spawn cycles → `spawn_count` = 3; preload the count near 0xFFFF → it saturates and does not wrap.
